noc_outport_arbiter: RTL and testbench



---
 rtl/noc_pkg.sv | 42 ++++
 rtl/noc_rr_arbiter5.sv | 50 +++++
 rtl/noc_outport_arbiter.sv | 138 +++++++++++++
 tb/tb_noc_outport_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : noc_pkg                                                   |
// | Description: Shared NoC router constants and the round-robin pick      |
// |              helper used by the output-port arbiters.                  |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package noc_pkg;

  localparam int NOC_PORTS = 5;

  localparam logic [2:0] DIR_NORTH = 3'd0;
  localparam logic [2:0] DIR_EAST  = 3'd1;
  localparam logic [2:0] DIR_SOUTH = 3'd2;
  localparam logic [2:0] DIR_WEST  = 3'd3;
  localparam logic [2:0] DIR_LOCAL = 3'd4;

  // Starting "last" pointer so that input 0 is searched first after reset.
  localparam logic [2:0] RR_LAST_RESET = 3'(NOC_PORTS - 1);

  // One-hot round-robin pick: search begins at last+1 and wraps 4->0.
  function automatic logic [NOC_PORTS-1:0] rr_pick(
    input logic [NOC_PORTS-1:0] req,
    input logic [2:0]           last
  );
    logic [NOC_PORTS-1:0] gnt;
    logic                 found;
    logic [2:0]           idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= NOC_PORTS; k++) begin
      idx = 3'((int'(last) + k) % NOC_PORTS);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_rr_arbiter5.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : noc_rr_arbiter5                                           |
// | Description: Five-way round-robin arbiter. Holds the last-granted      |
// |              index and presents a one-hot grant for the eligible       |
// |              requests; the pointer moves only when advance is high     |
// |              and a grant is produced.                                  |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module noc_rr_arbiter5
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NOC_PORTS-1:0] elig,
  input  logic                 advance,
  output logic [NOC_PORTS-1:0] grant
);

  logic [2:0] last_grant_q;
  logic [2:0] last_grant_d;

  // Combinational pick relative to the last winner.
  always_comb begin
    grant = rr_pick(elig, last_grant_q);
  end

  // Remember the winner only when the grant is actually consumed.
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance) begin
      for (int i = 0; i < NOC_PORTS; i++) begin
        if (grant[i]) begin
          last_grant_d = 3'(i);
        end
      end
    end
  end

  // Pointer register; reset makes input 0 the first candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= RR_LAST_RESET;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_outport_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : noc_outport_arbiter                                       |
// | Description: Output side of one router direction. Round-robin picks    |
// |              one of five switch requests, acknowledges it with a       |
// |              one-cycle clear pulse and writes the flit through a       |
// |              one-entry holding register into the next hop's FIFO.      |
// |              Optional statistics: define NOC_OUTPORT_STATS_EN.         |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module noc_outport_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 288,
  parameter int POS_WIDTH  = 4,
  parameter int OUT_DIR    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NOC_PORTS-1:0][DATA_WIDTH-1:0] req_data,
  input  logic [NOC_PORTS-1:0]                 req_valid,
  output logic [NOC_PORTS-1:0]                 clear,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_valid,
  input  logic                                 out_busy
`ifdef NOC_OUTPORT_STATS_EN
  ,
  output logic [31:0]                          stat_flits,
  output logic [31:0]                          stat_stall,
  output logic [NOC_PORTS-1:0][15:0]           stat_grants
`endif
);

  // The destination field must fit in the flit and the direction must exist.
  if (OUT_DIR < 0 || OUT_DIR > int'(DIR_LOCAL) || 2 * POS_WIDTH > DATA_WIDTH) begin : g_cfg_error
    $error("noc_outport_arbiter: invalid OUT_DIR / POS_WIDTH / DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_full_q, hold_full_d;
  logic [NOC_PORTS-1:0]  clear_q, clear_d;

  logic                  drain;
  logic                  grant_ok;
  logic                  grant_en;
  logic [NOC_PORTS-1:0]  elig;
  logic [NOC_PORTS-1:0]  grant;
  logic [DATA_WIDTH-1:0] grant_data;

  // The FIFO write strobe comes straight from hold state and back-pressure.
  assign out_valid = hold_full_q & ~out_busy;
  assign out_data  = hold_data_q;
  assign clear     = clear_q;
  assign drain     = out_valid;

  // An input being acknowledged still shows its old flit, so mask it.
  assign elig     = req_valid & ~clear_q;
  assign grant_ok = ~hold_full_q | drain;
  assign grant_en = grant_ok & (|grant);

  noc_rr_arbiter5 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .elig    (elig),
    .advance (grant_ok),
    .grant   (grant)
  );

  // AND-OR mux of the winning flit (grant is one-hot or zero).
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NOC_PORTS; i++) begin
      grant_data = grant_data | (req_data[i] & {DATA_WIDTH{grant[i]}});
    end
  end

  // Hold register reload / drain and acknowledge generation.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q & ~drain;
    clear_d     = '0;
    if (grant_en) begin
      hold_data_d = grant_data;
      hold_full_d = 1'b1;
      clear_d     = grant;
    end
  end

  // Datapath registers; reset discards any held flit and pending clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      clear_q     <= '0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      clear_q     <= clear_d;
    end
  end

`ifdef NOC_OUTPORT_STATS_EN
  logic [31:0]                flits_q, flits_d;
  logic [31:0]                stall_q, stall_d;
  logic [NOC_PORTS-1:0][15:0] grants_q, grants_d;

  assign stat_flits  = flits_q;
  assign stat_stall  = stall_q;
  assign stat_grants = grants_q;

  // Free-running wrap-around counters for delivered flits, stalls, grants.
  always_comb begin
    flits_d  = drain ? flits_q + 32'd1 : flits_q;
    stall_d  = (hold_full_q & out_busy) ? stall_q + 32'd1 : stall_q;
    grants_d = grants_q;
    for (int i = 0; i < NOC_PORTS; i++) begin
      if (grant_en && grant[i]) begin
        grants_d[i] = grants_q[i] + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flits_q  <= '0;
      stall_q  <= '0;
      grants_q <= '0;
    end else begin
      flits_q  <= flits_d;
      stall_q  <= stall_d;
      grants_q <= grants_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_outport_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : tb_noc_outport_arbiter                                    |
// | Description: Self-checking bench for noc_outport_arbiter: fixed vector |
// |              table, then switch-model driven traffic compared against  |
// |              a behavioural reference, plus reset corner cases.         |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_noc_outport_arbiter;

  localparam int DW = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [4:0][DW-1:0] req_data;
  logic [4:0]         req_valid;
  logic [4:0]         clear;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_busy;
`ifdef NOC_OUTPORT_STATS_EN
  logic [31:0]        stat_flits;
  logic [31:0]        stat_stall;
  logic [4:0][15:0]   stat_grants;
`endif

  always #5 clk = ~clk;

  noc_outport_arbiter #(
    .DATA_WIDTH (DW),
    .POS_WIDTH  (4),
    .OUT_DIR    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_data  (req_data),
    .req_valid (req_valid),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_busy  (out_busy)
`ifdef NOC_OUTPORT_STATS_EN
    ,
    .stat_flits  (stat_flits),
    .stat_stall  (stat_stall),
    .stat_grants (stat_grants)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- fixed vector table ----------------
  typedef struct {
    logic [4:0]    rv;
    logic          busy;
    logic [4:0]    clr;
    logic          vld;
    logic [DW-1:0] dat;
  } vec_t;

  vec_t          tbl[12];
  logic [DW-1:0] fixed_d[5];

  // ---------------- behavioural reference ----------------
  logic [DW-1:0] sq[5][$];          // each switch holds at most one flit
  int            push_pct[5];
  int            busy_pct;
  bit            force_busy;

  bit            m_full;
  logic [DW-1:0] m_data;
  logic [4:0]    m_clear;
  int            m_last;
  int            m_flits, m_stall;
  int            m_grants[5];

  function automatic int rr_next(input logic [4:0] e, input int last);
    for (int k = 1; k <= 5; k++) begin
      int c;
      c = (last + k) % 5;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full  = 0;
    m_data  = '0;
    m_clear = '0;
    m_last  = 4;
    m_flits = 0;
    m_stall = 0;
    for (int i = 0; i < 5; i++) begin
      m_grants[i] = 0;
      sq[i].delete();
    end
  endtask

  // Called just after a rising edge, using the inputs that were applied before it.
  task automatic model_edge();
    bit         drain;
    logic [4:0] e;
    int         g;
    drain = m_full && !out_busy;
    if (drain) m_flits++;
    if (m_full && out_busy) m_stall++;
    // A switch that saw its clear advances to its next flit.
    for (int i = 0; i < 5; i++) if (m_clear[i] && sq[i].size() != 0) void'(sq[i].pop_front());
    e = req_valid & ~m_clear;
    g = (!m_full || drain) ? rr_next(e, m_last) : -1;
    if (g >= 0) begin
      m_data  = req_data[g];
      m_full  = 1;
      m_clear = 5'(1 << g);
      m_last  = g;
      m_grants[g]++;
    end else begin
      m_clear = '0;
      m_full  = m_full && !drain;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 5; i++) begin
      req_valid[i] = (sq[i].size() != 0);
      req_data[i]  = (sq[i].size() != 0) ? sq[i][0] : '0;
    end
  endtask

  // Entered at posedge+1: refill, drive, check, then advance one clock.
  task automatic run_cycle();
    for (int i = 0; i < 5; i++)
      if (sq[i].size() == 0 && $urandom_range(99) < push_pct[i]) sq[i].push_back(DW'($urandom));
    out_busy = force_busy ? 1'b1 : ($urandom_range(99) < busy_pct);
    drive_inputs();
    #1;
    chk("clear", DW'(clear), DW'(m_clear));
    chk("out_valid", DW'(out_valid), DW'(m_full && !out_busy));
    chk("out_data", out_data, m_data);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_push(input int p0, input int p1, input int p2, input int p3, input int p4);
    push_pct[0] = p0; push_pct[1] = p1; push_pct[2] = p2; push_pct[3] = p3; push_pct[4] = p4;
  endtask

  // Reset asserted between edges; outputs must clear immediately.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_clear"}, DW'(clear), '0);
    chk({tag, "_out_valid"}, DW'(out_valid), '0);
    chk({tag, "_out_data"}, out_data, '0);
    model_reset();
    drive_inputs();
    out_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // After reset, with everyone requesting, input 0 must be acknowledged first.
  task automatic first_grant_check(input string tag);
    bit seen;
    seen = 0;
    set_push(100, 100, 100, 100, 100);
    busy_pct = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      run_cycle();
      if (m_clear != 0) seen = 1;
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s: no grant within 8 cycles", tag);
    end else begin
      chk(tag, DW'(clear), DW'(5'b00001));
    end
  endtask

  initial begin
    fixed_d[0] = 32'h10; fixed_d[1] = 32'h11; fixed_d[2] = 32'hA5;
    fixed_d[3] = 32'h13; fixed_d[4] = 32'h14;
    //          rv        busy  clr       vld   data
    tbl[0]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 32'h00};
    tbl[1]  = '{5'b00100, 1'b0, 5'b00000, 1'b0, 32'h00};
    tbl[2]  = '{5'b00100, 1'b0, 5'b00100, 1'b1, 32'hA5};
    tbl[3]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 32'hA5};
    tbl[4]  = '{5'b11011, 1'b0, 5'b00000, 1'b0, 32'hA5};
    tbl[5]  = '{5'b11011, 1'b1, 5'b01000, 1'b0, 32'h13};
    tbl[6]  = '{5'b10011, 1'b1, 5'b00000, 1'b0, 32'h13};
    tbl[7]  = '{5'b10011, 1'b0, 5'b00000, 1'b1, 32'h13};
    tbl[8]  = '{5'b10011, 1'b0, 5'b10000, 1'b1, 32'h14};
    tbl[9]  = '{5'b00011, 1'b0, 5'b00001, 1'b1, 32'h10};
    tbl[10] = '{5'b00010, 1'b0, 5'b00010, 1'b1, 32'h11};
    tbl[11] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 32'h11};

    req_valid  = '0;
    req_data   = '0;
    out_busy   = 1'b0;
    force_busy = 0;
    busy_pct   = 0;
    set_push(0, 0, 0, 0, 0);
    model_reset();

    // Reset state.
    #2;
    chk("reset_clear", DW'(clear), '0);
    chk("reset_out_valid", DW'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table vectors, one row per cycle.
    for (int r = 0; r < 12; r++) begin
      req_valid = tbl[r].rv;
      for (int i = 0; i < 5; i++) req_data[i] = fixed_d[i];
      out_busy = tbl[r].busy;
      #1;
      chk($sformatf("tbl%0d_clear", r), DW'(clear), DW'(tbl[r].clr));
      chk($sformatf("tbl%0d_out_valid", r), DW'(out_valid), DW'(tbl[r].vld));
      chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].dat);
      @(posedge clk);
      #1;
    end

    // Fresh start for model-driven traffic.
    async_reset("rst1");
    first_grant_check("rst1_first_grant");

    // All five refill continuously.
    set_push(100, 100, 100, 100, 100);
    for (int n = 0; n < 20; n++) run_cycle();

    // Let the others empty, then a single back-to-back input.
    set_push(0, 100, 0, 0, 0);
    for (int n = 0; n < 20; n++) run_cycle();

    // Three inputs pending while the downstream FIFO is busy for 10 cycles.
    set_push(100, 0, 100, 100, 0);
    for (int n = 0; n < 3; n++) run_cycle();
    force_busy = 1;
    for (int n = 0; n < 10; n++) run_cycle();
    force_busy = 0;
    for (int n = 0; n < 8; n++) run_cycle();

    // Random traffic with random back-pressure.
    set_push(50, 50, 50, 50, 50);
    busy_pct = 30;
    for (int n = 0; n < 300; n++) run_cycle();

    // Reset while hold is full and a clear is pending.
    begin
      bit armed;
      armed = 0;
      set_push(100, 100, 100, 100, 100);
      busy_pct = 0;
      for (int n = 0; n < 10 && !armed; n++) begin
        run_cycle();
        if (m_clear != 0 && m_full) armed = 1;
      end
      if (!armed) begin
        errors++;
        checks++;
        $display("FAIL midreset_arm: hold never became full with clear pending");
      end
    end
    async_reset("midrst");
    first_grant_check("midrst_first_grant");

    set_push(70, 20, 90, 40, 60);
    busy_pct = 25;
    for (int n = 0; n < 200; n++) run_cycle();

`ifdef NOC_OUTPORT_STATS_EN
    begin
      int sum_dut;
      int sum_ref;
      sum_dut = 0;
      sum_ref = 0;
      chk("stat_flits", stat_flits, DW'(m_flits));
      chk("stat_stall", stat_stall, DW'(m_stall));
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("stat_grants%0d", i), DW'(stat_grants[i]), DW'(m_grants[i]));
        sum_dut += int'(stat_grants[i]);
        sum_ref += m_grants[i];
      end
      chk("stat_grants_sum", DW'(sum_dut), DW'(sum_ref));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
